// File: rtl/pe_glb_load_ctrl.sv
// Sequences one weight/ifmap load into a PE from a single shared GLB read port,
// arbitrating round-robin between the weight and feature streams.
module pe_glb_load_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [LEN_WIDTH-1:0]  w_len,
  input  logic [ADDR_WIDTH-1:0] f_base,
  input  logic [LEN_WIDTH-1:0]  f_len,
  input  logic                  pe_weight_load_ready,
  input  logic                  pe_ifmap_load_ready,
  input  logic [DATA_WIDTH-1:0] glb_rd_data,
  output logic                  glb_rd_en,
  output logic [ADDR_WIDTH-1:0] glb_rd_addr,
  output logic                  start_weight_load,
  output logic                  start_feature_load,
  output logic [DATA_WIDTH-1:0] bus_weight_in,
  output logic                  bus_weight_valid,
  output logic [DATA_WIDTH-1:0] bus_feature_in,
  output logic                  bus_feature_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] w_base_q, f_base_q;
  logic [LEN_WIDTH-1:0]  w_len_q, f_len_q;
  logic [LEN_WIDTH-1:0]  w_cnt, f_cnt;
  logic                  last_f;
  logic                  sel_pipe;
  logic                  w_req, f_req, w_gnt, f_gnt, w_fin, f_fin;

  assign bus_weight_in  = glb_rd_data;
  assign bus_feature_in = glb_rd_data;

  // last_f=1 means feature was granted last, so weight wins the next tie
  always_comb begin
    w_req = (w_cnt < w_len_q) && pe_weight_load_ready;
    f_req = (f_cnt < f_len_q) && pe_ifmap_load_ready;
    w_gnt = (state == STREAM) && w_req && (!f_req || last_f);
    f_gnt = (state == STREAM) && f_req && !w_gnt;
    w_fin = (w_cnt + LEN_WIDTH'(w_gnt)) == w_len_q;
    f_fin = (f_cnt + LEN_WIDTH'(f_gnt)) == f_len_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      w_base_q           <= '0;
      f_base_q           <= '0;
      w_len_q            <= '0;
      f_len_q            <= '0;
      w_cnt              <= '0;
      f_cnt              <= '0;
      last_f             <= 1'b1;
      sel_pipe           <= 1'b0;
      glb_rd_en          <= 1'b0;
      glb_rd_addr        <= '0;
      start_weight_load  <= 1'b0;
      start_feature_load <= 1'b0;
      bus_weight_valid   <= 1'b0;
      bus_feature_valid  <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      start_weight_load  <= 1'b0;
      start_feature_load <= 1'b0;
      done               <= 1'b0;
      glb_rd_en          <= 1'b0;
      bus_weight_valid   <= glb_rd_en & ~sel_pipe;
      bus_feature_valid  <= glb_rd_en & sel_pipe;

      case (state)
        IDLE: begin
          if (cmd_start) begin
            w_base_q           <= w_base;
            f_base_q           <= f_base;
            w_len_q            <= w_len;
            f_len_q            <= f_len;
            w_cnt              <= '0;
            f_cnt              <= '0;
            last_f             <= 1'b1;
            start_weight_load  <= (w_len != '0);
            start_feature_load <= (f_len != '0);
            busy               <= 1'b1;
            state              <= START;
          end
        end
        START: begin
          state <= (w_len_q == '0 && f_len_q == '0) ? DRAIN : STREAM;
        end
        STREAM: begin
          if (w_gnt) begin
            glb_rd_en   <= 1'b1;
            glb_rd_addr <= w_base_q + ADDR_WIDTH'(w_cnt);
            sel_pipe    <= 1'b0;
            w_cnt       <= w_cnt + 1'b1;
            last_f      <= 1'b0;
          end else if (f_gnt) begin
            glb_rd_en   <= 1'b1;
            glb_rd_addr <= f_base_q + ADDR_WIDTH'(f_cnt);
            sel_pipe    <= 1'b1;
            f_cnt       <= f_cnt + 1'b1;
            last_f      <= 1'b1;
          end
          if (w_fin && f_fin) state <= DRAIN;
        end
        DRAIN: begin
          // Once no read is outstanding, both valid registers clear on this edge
          if (!glb_rd_en) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_glb_load_ctrl.sv
// Directed self-checking bench for pe_glb_load_ctrl with a 1-cycle-latency GLB model.
module tb_pe_glb_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [7:0]  w_base, f_base, w_len, f_len;
  logic        pe_weight_load_ready, pe_ifmap_load_ready;
  logic [15:0] glb_rd_data;
  logic        glb_rd_en;
  logic [7:0]  glb_rd_addr;
  logic        start_weight_load, start_feature_load;
  logic [15:0] bus_weight_in, bus_feature_in;
  logic        bus_weight_valid, bus_feature_valid;
  logic        busy, done;

  pe_glb_load_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
    .w_base(w_base), .w_len(w_len), .f_base(f_base), .f_len(f_len),
    .pe_weight_load_ready(pe_weight_load_ready), .pe_ifmap_load_ready(pe_ifmap_load_ready),
    .glb_rd_data(glb_rd_data), .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr),
    .start_weight_load(start_weight_load), .start_feature_load(start_feature_load),
    .bus_weight_in(bus_weight_in), .bus_weight_valid(bus_weight_valid),
    .bus_feature_in(bus_feature_in), .bus_feature_valid(bus_feature_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] glb_word(input logic [7:0] a);
    return {~a, a} ^ 16'h3C00;
  endfunction

  always @(posedge clk) if (glb_rd_en) glb_rd_data <= glb_word(glb_rd_addr);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic w_rdy_q = 1'b0;
  logic [7:0] cur_w_base = '0, cur_w_len = '0;

  int rd_addr_q[$], rd_cyc_q[$], wv_q[$], fv_q[$], exp_rd[$];
  int sw_cnt, sf_cnt, sw_cyc, done_cnt, done_cyc, busy_cycles, busy_at_done;
  int bad_w_rd, win_f_rd, cmd_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    w_rdy_q <= pe_weight_load_ready;
  end

  always @(negedge clk) begin
    if (glb_rd_en) begin
      rd_addr_q.push_back(int'(glb_rd_addr));
      rd_cyc_q.push_back(cyc);
      if (!w_rdy_q) begin
        if (8'(glb_rd_addr - cur_w_base) < cur_w_len) bad_w_rd++;
        else win_f_rd++;
      end
    end
    if (bus_weight_valid)  wv_q.push_back(int'(bus_weight_in));
    if (bus_feature_valid) fv_q.push_back(int'(bus_feature_in));
    if (start_weight_load) begin sw_cnt++; sw_cyc = cyc; end
    if (start_feature_load) sf_cnt++;
    if (busy) busy_cycles++;
    if (done) begin done_cnt++; done_cyc = cyc; if (busy) busy_at_done++; end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_addr_q = {}; rd_cyc_q = {}; wv_q = {}; fv_q = {};
    sw_cnt = 0; sf_cnt = 0; sw_cyc = 0; done_cnt = 0; done_cyc = 0;
    busy_cycles = 0; busy_at_done = 0; bad_w_rd = 0; win_f_rd = 0;
  endtask

  task automatic issue(input logic [7:0] wb, input logic [7:0] wl,
                       input logic [7:0] fb, input logic [7:0] fl);
    clear_logs();
    w_base = wb; w_len = wl; f_base = fb; f_len = fl;
    cur_w_base = wb; cur_w_len = wl;
    cmd_start = 1'b1;
    cmd_cyc = cyc;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check("done_seen", int'(done_cnt != d0), 1);
    repeat (3) tick();
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd_count"}, rd_addr_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_addr_q.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_addr_q[i], exp_rd[i]);
  endtask

  task automatic check_data(input string tag, input logic [7:0] wb, input int wl,
                            input logic [7:0] fb, input int fl);
    check({tag, "_wv_count"}, wv_q.size(), wl);
    check({tag, "_fv_count"}, fv_q.size(), fl);
    for (int i = 0; i < wl && i < wv_q.size(); i++)
      check($sformatf("%s_wdata%0d", tag, i), wv_q[i], int'(glb_word(wb + 8'(i))));
    for (int i = 0; i < fl && i < fv_q.size(); i++)
      check($sformatf("%s_fdata%0d", tag, i), fv_q[i], int'(glb_word(fb + 8'(i))));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0;
    w_base = '0; w_len = '0; f_base = '0; f_len = '0;
    pe_weight_load_ready = 1'b1; pe_ifmap_load_ready = 1'b1;
    glb_rd_data = '0;
    clear_logs();
    repeat (2) tick();
    check("reset_outputs", int'({glb_rd_en, glb_rd_addr, start_weight_load, start_feature_load,
                                 bus_weight_valid, bus_feature_valid, busy, done}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Weight-only stream of 9 words
    issue(8'h00, 8'd9, 8'h00, 8'd0);
    wait_done(60);
    exp_rd = {0, 1, 2, 3, 4, 5, 6, 7, 8};
    check_reads("t1");
    check_data("t1", 8'h00, 9, 8'h00, 0);
    check("t1_sw_cnt", sw_cnt, 1);
    check("t1_sf_cnt", sf_cnt, 0);
    check("t1_sw_latency", sw_cyc - cmd_cyc, 1);
    check("t1_first_rd_latency", rd_cyc_q.size() > 0 ? rd_cyc_q[0] - cmd_cyc : -1, 3);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_at_done", busy_at_done, 0);

    // Interleaved weight/feature, both ready
    issue(8'h00, 8'd4, 8'h40, 8'd4);
    wait_done(60);
    exp_rd = {'h00, 'h40, 'h01, 'h41, 'h02, 'h42, 'h03, 'h43};
    check_reads("t2");
    check_data("t2", 8'h00, 4, 8'h40, 4);
    check("t2_sw_sf", sw_cnt * 16 + sf_cnt, 'h11);
    check("t2_done_after_last_rd", rd_cyc_q.size() > 0 ? done_cyc - rd_cyc_q[$] : -1, 2);

    // Weight ready low for 5 edges starting at the 4th STREAM edge
    issue(8'h00, 8'd9, 8'h80, 8'd8);
    repeat (4) tick();
    pe_weight_load_ready = 1'b0;
    repeat (5) tick();
    pe_weight_load_ready = 1'b1;
    wait_done(80);
    exp_rd = {'h00, 'h80, 'h01, 'h81, 'h82, 'h83, 'h84, 'h85, 'h02, 'h86, 'h03, 'h87,
              'h04, 'h05, 'h06, 'h07, 'h08};
    check_reads("t3");
    check_data("t3", 8'h00, 9, 8'h80, 8);
    check("t3_w_reads_while_not_ready", bad_w_rd, 0);
    check("t3_f_reads_in_window", win_f_rd, 5);

    // Address wrap, plus a cmd_start while busy that must be ignored
    issue(8'hFE, 8'd4, 8'h00, 8'd0);
    tick();
    w_base = 8'h10; w_len = 8'd7; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_done(60);
    repeat (5) tick();
    exp_rd = {'hFE, 'hFF, 'h00, 'h01};
    check_reads("t4");
    check_data("t4", 8'hFE, 4, 8'h00, 0);
    check("t4_sw_cnt", sw_cnt, 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_idle_busy", int'(busy), 0);

    // Both lengths zero
    issue(8'h00, 8'd0, 8'h00, 8'd0);
    wait_done(20);
    exp_rd = {};
    check_reads("t5");
    check("t5_starts", sw_cnt + sf_cnt, 0);
    check("t5_busy_cycles", busy_cycles, 2);
    check("t5_done_latency", done_cyc - cmd_cyc, 3);

    // Reset mid-stream abandons the transfer
    issue(8'h20, 8'd20, 8'h00, 8'd0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 check("t6_reset_outputs", int'({glb_rd_en, glb_rd_addr, start_weight_load, start_feature_load,
                                       bus_weight_valid, bus_feature_valid, busy, done}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_idle_busy", int'(busy), 0);

    // New command after reset completes normally
    issue(8'h30, 8'd3, 8'h50, 8'd2);
    wait_done(40);
    exp_rd = {'h30, 'h50, 'h31, 'h51, 'h32};
    check_reads("t7");
    check_data("t7", 8'h30, 3, 8'h50, 2);
    check("t7_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
